stream_demux: RTL and testbench
===============================

# stream_demux

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking. It routes each input beat to one of N_CH output channels, either by an explicit per-beat select or by an internal round-robin pointer. It sits between the line-buffer/window stage and the parallel convolution lanes, fanning a single pixel stream out to per-lane consumers. It generalises the team's combinational 8-way 1-bit demux to arbitrary width and channel count, adds backpressure, and adds a one-beat output register per channel.

## Interface
- DATA_W, 8, width of one data beat.
- N_CH, 8, number of output channels; must be 2 or more.
- SEL_W, $clog2(N_CH), select and pointer width; derived, do not override.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = addressed (use in_sel), 1 = round-robin (use internal pointer); sampled per beat.
- in_data  in  DATA_W  input beat.
- in_sel  in  SEL_W  target channel in addressed mode; ignored in round-robin mode.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- out_data  out  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  out  N_CH  per-channel beat present.
- out_ready  in  N_CH  per-channel consumer ready.
- rr_ptr  out  SEL_W  current round-robin target.
- sel_err  out  1  one-cycle pulse when an addressed beat with in_sel >= N_CH is accepted and discarded.

One clock; reset is synchronous and active-high (clk, rst).

## Operation
- Target for the current beat: `tgt = mode ? rr_ptr : in_sel`.
- `in_ready` is combinational: 1 if `tgt >= N_CH`, otherwise `~out_valid[tgt] | out_ready[tgt]`. It depends only on `tgt`, never on other channels, so a stalled lane blocks only beats addressed to it.
- Accept when `in_valid & in_ready`:
  - If `tgt < N_CH`: load `in_data` into the channel `tgt` register and set `out_valid[tgt] = 1`.
  - If `tgt >= N_CH`: this can happen only in addressed mode with N_CH not a power of two. The beat is dropped, no output changes, and `sel_err` pulses the next cycle.
- Channel k drain: when `out_valid[k] & out_ready[k]` and there is no new accept to k, clear `out_valid[k]`.
- Simultaneous drain and accept on the same channel: `out_valid[k]` stays 1 and the data is replaced by the new beat. This gives full throughput of one beat per cycle per channel.
- Channel data registers hold their last value when not loaded. Consumers must qualify data with `out_valid`.
- Round-robin pointer:
  - Advances only on an accepted beat with `mode = 1`.
  - Wraps from N_CH-1 to 0.
  - Holds in addressed mode, so switching modes resumes from the held value.
- `in_valid` low: no state change except drains.

## Timing
- Reset values: `out_valid` all 0, `out_data` all 0, `rr_ptr` 0, `sel_err` 0. `in_ready` follows combinationally, so it is 1 after reset.
- Latency: a beat accepted at edge t appears on `out_data`/`out_valid` in the cycle after edge t (1 cycle).
- `rr_ptr` update is visible in the cycle after the accepting edge.
- Throughput: one beat per cycle in total. In round-robin mode with all consumers ready, each channel receives every N_CH-th beat.
- Reset asserted mid-operation: pending output beats are discarded (`out_valid` cleared at that edge) and the pointer returns to 0. No beat is accepted while `rst` = 1, regardless of `in_ready`.
- Output-side protocol: `out_data[k]` is stable while `out_valid[k] & ~out_ready[k]`.
- Input-side protocol: the bench holds `in_data`/`in_sel`/`mode` stable while `in_valid & ~in_ready`.

## Test plan
- **Addressed routing:** DATA_W=8, N_CH=8, mode=0, all out_ready=1; send 0xA0..0xA7 with in_sel=0..7 on consecutive cycles -> channel k shows 0xA0+k with out_valid[k] high for exactly one cycle, 1 cycle after its input.
- **Round-robin wrap:** mode=1; send 10 beats 0x10..0x19 -> channels 0..7 get 0x10..0x17, then channels 0,1 get 0x18,0x19; rr_ptr reads 2 at the end.
- **Backpressure isolation:** out_ready[3]=0; send 0x55 to ch3, then 0x66 to ch3, then 0x77 to ch4 -> in_ready low on the 0x66 beat; 0x77 accepted and delivered; ch3 holds 0x55. Raise out_ready[3] -> 0x66 delivered next cycle.
- **Simultaneous drain and accept:** ch2 full with 0x11, out_ready[2]=1, new beat 0x22 to ch2 in the same cycle -> in_ready=1, out_valid[2] stays 1, out_data lane 2 = 0x22 next cycle.
- **Invalid select:** N_CH=6, mode=0, in_sel=7, data 0x99 -> accepted, all out_valid stay 0, sel_err pulses for 1 cycle.
- **Reset mid-stream:** N_CH=8, mode=1, rr_ptr=5, ch1 and ch4 holding undrained beats; assert rst for 1 cycle with in_valid=1 -> out_valid = 0, out_data = 0, rr_ptr = 0, no beat accepted during reset.

Source files
------------

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with valid/ready handshaking.
// Beats are steered by an explicit select or by an internal round-robin pointer.
module stream_demux #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_CH   = 8,
    parameter int unsigned SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [SEL_W-1:0]         rr_ptr,
    output logic                     sel_err
);

    // Select space padded to a power of two so out-of-range targets index safely.
    localparam int unsigned NPad = 1 << SEL_W;

    logic [SEL_W-1:0]  tgt;
    logic              tgt_ok;
    logic              accept;
    logic [NPad-1:0]   valid_pad;
    logic [NPad-1:0]   ready_pad;

    logic [N_CH-1:0]   valid_q, valid_d;
    logic [N_CH-1:0]   load;
    logic [DATA_W-1:0] data_q [N_CH];
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic              err_q, err_d;

    // Readiness looks only at the targeted lane, so a stalled lane blocks only its own beats.
    always_comb begin
        tgt       = mode ? ptr_q : in_sel;
        tgt_ok    = (32'(tgt) < N_CH);
        valid_pad = '0;
        ready_pad = '0;
        valid_pad[N_CH-1:0] = valid_q;
        ready_pad[N_CH-1:0] = out_ready;
        in_ready  = ~tgt_ok | ~valid_pad[tgt] | ready_pad[tgt];
        accept    = in_valid & in_ready;
    end

    always_comb begin
        load    = '0;
        valid_d = valid_q;
        for (int unsigned k = 0; k < N_CH; k++) begin
            load[k]    = accept & tgt_ok & (tgt == SEL_W'(k));
            valid_d[k] = load[k] | (valid_q[k] & ~out_ready[k]);
        end
        ptr_d = ptr_q;
        if (accept && mode) begin
            ptr_d = (ptr_q == SEL_W'(N_CH - 1)) ? '0 : ptr_q + SEL_W'(1);
        end
        err_d = accept & ~tgt_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            out_data[k*DATA_W +: DATA_W] = data_q[k];
        end
    end

    assign out_valid = valid_q;
    assign rr_ptr    = ptr_q;
    assign sel_err   = err_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: an 8-channel and a 6-channel instance driven side by side,
// checked against a per-channel occupancy model plus directed literal expectations.
module tb_stream_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       i_mode   [2];
    logic [7:0] i_data   [2];
    logic [2:0] i_sel    [2];
    logic       i_valid  [2];
    logic [7:0] i_oready [2];

    logic        a_rdy, b_rdy;
    logic [63:0] a_od;
    logic [47:0] b_od;
    logic [7:0]  a_ov;
    logic [5:0]  b_ov;
    logic [2:0]  a_ptr, b_ptr;
    logic        a_err, b_err;

    stream_demux #(.DATA_W(8), .N_CH(8)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .mode      (i_mode[0]),
        .in_data   (i_data[0]),
        .in_sel    (i_sel[0]),
        .in_valid  (i_valid[0]),
        .in_ready  (a_rdy),
        .out_data  (a_od),
        .out_valid (a_ov),
        .out_ready (i_oready[0]),
        .rr_ptr    (a_ptr),
        .sel_err   (a_err)
    );

    stream_demux #(.DATA_W(8), .N_CH(6)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .mode      (i_mode[1]),
        .in_data   (i_data[1]),
        .in_sel    (i_sel[1]),
        .in_valid  (i_valid[1]),
        .in_ready  (b_rdy),
        .out_data  (b_od),
        .out_valid (b_ov),
        .out_ready (i_oready[1][5:0]),
        .rr_ptr    (b_ptr),
        .sel_err   (b_err)
    );

    // Model: which channels hold a beat, what it is, pointer, and pending error pulse.
    bit         mv [2][8];
    logic [7:0] md [2][8];
    int         mp [2];
    bit         me [2];
    int         checks = 0;
    int         errors = 0;

    function automatic int nch(input int d);
        return (d == 0) ? 8 : 6;
    endfunction

    function automatic bit m_ready(input int d);
        int tgt;
        tgt = i_mode[d] ? mp[d] : int'(i_sel[d]);
        if (tgt >= nch(d)) return 1'b1;
        return !mv[d][tgt] || i_oready[d][tgt];
    endfunction

    task automatic idle();
        for (int d = 0; d < 2; d++) i_valid[d] = 1'b0;
    endtask

    // One clock: compare in_ready before the edge, advance the model, compare outputs after.
    task automatic cycle(input bit chk_rdy);
        bit         er [2];
        bit         acc;
        int         tgt;
        logic [7:0]  ev [2];
        logic [63:0] ed [2];
        #1;
        er[0] = m_ready(0);
        er[1] = m_ready(1);
        if (chk_rdy) begin
            checks += 2;
            if (a_rdy !== er[0]) begin
                errors++;
                $display("FAIL in_ready_a: got %b want %b", a_rdy, er[0]);
            end
            if (b_rdy !== er[1]) begin
                errors++;
                $display("FAIL in_ready_b: got %b want %b", b_rdy, er[1]);
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int k = 0; k < 8; k++) begin
                    mv[d][k] = 1'b0;
                    md[d][k] = 8'h00;
                end
                mp[d] = 0;
                me[d] = 1'b0;
            end else begin
                tgt   = i_mode[d] ? mp[d] : int'(i_sel[d]);
                acc   = i_valid[d] && er[d];
                me[d] = acc && (tgt >= nch(d));
                for (int k = 0; k < nch(d); k++) begin
                    if (acc && tgt == k) begin
                        mv[d][k] = 1'b1;
                        md[d][k] = i_data[d];
                    end else if (i_oready[d][k]) begin
                        mv[d][k] = 1'b0;
                    end
                end
                if (acc && i_mode[d]) mp[d] = (mp[d] + 1) % nch(d);
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            ev[d] = '0;
            ed[d] = '0;
            for (int k = 0; k < nch(d); k++) begin
                ev[d][k]        = mv[d][k];
                ed[d][k*8 +: 8] = md[d][k];
            end
        end
        checks += 8;
        if (a_ov !== ev[0]) begin
            errors++; $display("FAIL out_valid_a: got %h want %h", a_ov, ev[0]);
        end
        if (a_od !== ed[0]) begin
            errors++; $display("FAIL out_data_a: got %h want %h", a_od, ed[0]);
        end
        if (a_ptr !== 3'(mp[0])) begin
            errors++; $display("FAIL rr_ptr_a: got %0d want %0d", a_ptr, mp[0]);
        end
        if (a_err !== me[0]) begin
            errors++; $display("FAIL sel_err_a: got %b want %b", a_err, me[0]);
        end
        if (b_ov !== ev[1][5:0]) begin
            errors++; $display("FAIL out_valid_b: got %h want %h", b_ov, ev[1][5:0]);
        end
        if (b_od !== ed[1][47:0]) begin
            errors++; $display("FAIL out_data_b: got %h want %h", b_od, ed[1][47:0]);
        end
        if (b_ptr !== 3'(mp[1])) begin
            errors++; $display("FAIL rr_ptr_b: got %0d want %0d", b_ptr, mp[1]);
        end
        if (b_err !== me[1]) begin
            errors++; $display("FAIL sel_err_b: got %b want %b", b_err, me[1]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        cycle(1'b0);
        rst = 1'b0;
        #1;
        checks += 4;
        if (a_ov !== 8'h00 || b_ov !== 6'h00) begin
            errors++; $display("FAIL reset_valid: got %h/%h want 0/0", a_ov, b_ov);
        end
        if (a_od !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", a_od);
        end
        if (a_ptr !== 3'd0 || a_err !== 1'b0) begin
            errors++; $display("FAIL reset_ptr_err: got %0d/%b want 0/0", a_ptr, a_err);
        end
        if (a_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", a_rdy);
        end
    endtask

    task automatic test_addressed();
        i_oready[0] = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            i_mode[0] = 1'b0; i_sel[0] = 3'(k); i_data[0] = 8'(8'hA0 + k); i_valid[0] = 1'b1;
            cycle(1'b1);
            checks++;
            if (a_ov !== 8'(1 << k) || a_od[k*8 +: 8] !== 8'(8'hA0 + k)) begin
                errors++;
                $display("FAIL addressed_ch%0d: got v=%h d=%h want v=%h d=%h",
                         k, a_ov, a_od[k*8 +: 8], 8'(1 << k), 8'(8'hA0 + k));
            end
        end
        idle();
        cycle(1'b1);
        checks++;
        if (a_ov !== 8'h00) begin
            errors++; $display("FAIL addressed_drain: got %h want 00", a_ov);
        end
    endtask

    task automatic test_rr_wrap();
        for (int i = 0; i < 10; i++) begin
            i_mode[0] = 1'b1; i_data[0] = 8'(8'h10 + i); i_valid[0] = 1'b1;
            i_sel[0] = 3'($urandom_range(7));
            cycle(1'b1);
            checks++;
            if (a_ov !== 8'(1 << (i % 8)) || a_od[(i % 8)*8 +: 8] !== 8'(8'h10 + i)) begin
                errors++;
                $display("FAIL rr_beat%0d: got v=%h d=%h want v=%h d=%h", i, a_ov,
                         a_od[(i % 8)*8 +: 8], 8'(1 << (i % 8)), 8'(8'h10 + i));
            end
        end
        idle();
        cycle(1'b1);
        checks++;
        if (a_ptr !== 3'd2) begin
            errors++; $display("FAIL rr_final_ptr: got %0d want 2", a_ptr);
        end
    endtask

    task automatic test_backpressure();
        i_oready[0] = 8'hF7;
        i_mode[0] = 1'b0; i_sel[0] = 3'd3; i_data[0] = 8'h55; i_valid[0] = 1'b1;
        cycle(1'b1);
        i_data[0] = 8'h66;
        #1;
        checks++;
        if (a_rdy !== 1'b0) begin
            errors++; $display("FAIL bp_blocked: got in_ready %b want 0", a_rdy);
        end
        cycle(1'b1);
        i_sel[0] = 3'd4; i_data[0] = 8'h77;
        #1;
        checks++;
        if (a_rdy !== 1'b1) begin
            errors++; $display("FAIL bp_other_lane: got in_ready %b want 1", a_rdy);
        end
        cycle(1'b1);
        checks++;
        if (a_ov[4] !== 1'b1 || a_od[39:32] !== 8'h77 || a_ov[3] !== 1'b1 ||
            a_od[31:24] !== 8'h55) begin
            errors++;
            $display("FAIL bp_isolation: got v=%h ch3=%h ch4=%h want ch3=55 ch4=77",
                     a_ov, a_od[31:24], a_od[39:32]);
        end
        i_oready[0] = 8'hFF; i_sel[0] = 3'd3; i_data[0] = 8'h66;
        cycle(1'b1);
        checks++;
        if (a_ov !== 8'h08 || a_od[31:24] !== 8'h66) begin
            errors++; $display("FAIL bp_release: got v=%h ch3=%h want 08/66", a_ov, a_od[31:24]);
        end
        idle();
        cycle(1'b1);
    endtask

    task automatic test_drain_accept();
        i_oready[0] = 8'hFB;
        i_mode[0] = 1'b0; i_sel[0] = 3'd2; i_data[0] = 8'h11; i_valid[0] = 1'b1;
        cycle(1'b1);
        i_oready[0] = 8'hFF; i_data[0] = 8'h22;
        #1;
        checks++;
        if (a_ov[2] !== 1'b1 || a_od[23:16] !== 8'h11 || a_rdy !== 1'b1) begin
            errors++;
            $display("FAIL da_setup: got v2=%b d=%h rdy=%b want 1/11/1",
                     a_ov[2], a_od[23:16], a_rdy);
        end
        cycle(1'b1);
        checks++;
        if (a_ov[2] !== 1'b1 || a_od[23:16] !== 8'h22) begin
            errors++; $display("FAIL da_replace: got v2=%b d=%h want 1/22", a_ov[2], a_od[23:16]);
        end
        idle();
        cycle(1'b1);
    endtask

    task automatic test_invalid_sel();
        i_oready[1] = 8'hFF;
        i_mode[1] = 1'b0; i_sel[1] = 3'd7; i_data[1] = 8'h99; i_valid[1] = 1'b1;
        #1;
        checks++;
        if (b_rdy !== 1'b1) begin
            errors++; $display("FAIL inv_ready: got %b want 1", b_rdy);
        end
        cycle(1'b1);
        checks++;
        if (b_ov !== 6'h00 || b_err !== 1'b1) begin
            errors++; $display("FAIL inv_drop: got v=%h err=%b want 00/1", b_ov, b_err);
        end
        idle();
        cycle(1'b1);
        checks++;
        if (b_err !== 1'b0) begin
            errors++; $display("FAIL inv_pulse: got err=%b want 0", b_err);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        idle();
        cycle(1'b1);
        rst = 1'b0;
        i_oready[0] = 8'hED;
        for (int i = 0; i < 5; i++) begin
            i_mode[0] = 1'b1; i_data[0] = 8'(8'h30 + i); i_valid[0] = 1'b1;
            cycle(1'b1);
        end
        checks++;
        if (a_ptr !== 3'd5 || a_ov !== 8'h12) begin
            errors++; $display("FAIL rm_setup: got ptr=%0d v=%h want 5/12", a_ptr, a_ov);
        end
        rst = 1'b1; i_data[0] = 8'hEE;
        cycle(1'b1);
        checks++;
        if (a_ov !== 8'h00 || a_od !== 64'h0 || a_ptr !== 3'd0) begin
            errors++; $display("FAIL rm_clear: got v=%h d=%h ptr=%0d want 0", a_ov, a_od, a_ptr);
        end
        rst = 1'b0;
        idle();
        cycle(1'b1);
        checks++;
        if (a_ov !== 8'h00) begin
            errors++; $display("FAIL rm_no_accept: got v=%h want 00", a_ov);
        end
        i_oready[0] = 8'hFF;
    endtask

    task automatic test_random();
        bit stall [2];
        for (int n = 0; n < 800; n++) begin
            for (int d = 0; d < 2; d++) begin
                if (!stall[d]) begin
                    i_mode[d]  = 1'($urandom_range(1));
                    i_sel[d]   = 3'($urandom_range(7));
                    i_data[d]  = 8'($urandom);
                    i_valid[d] = ($urandom_range(3) != 0);
                end
                for (int k = 0; k < 8; k++) i_oready[d][k] = ($urandom_range(3) != 0);
            end
            rst = ($urandom_range(99) == 0);
            #1;
            for (int d = 0; d < 2; d++) stall[d] = i_valid[d] && (!m_ready(d) || rst);
            cycle(1'b1);
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            i_mode[d] = 1'b0; i_data[d] = 8'h00; i_sel[d] = 3'd0;
            i_valid[d] = 1'b0; i_oready[d] = 8'hFF;
        end
        @(negedge clk);
        test_reset();
        test_addressed();
        test_rr_wrap();
        test_backpressure();
        test_drain_accept();
        test_invalid_sel();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
